// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit of the segmented RISC-V core.
// Runs a req/ack access to data memory, builds byte enables and lane-replicated
// store data, and sign/zero-extends load data for the MEM/WB register.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses trap instead of
// being forced onto an aligned lane.
module mem_stage_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  valid_in,
  input  logic                  flush,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            func_3_bits,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misalign_trap
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_e                state_q;
  logic                  req_q, we_q, done_q, kill_q, sext_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q, load_q;
  logic [1:0]            off_q, size_q;

  logic                  start;
  logic [1:0]            size_d, off_d;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wdata_d, load_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  unused_addr_bits;

  assign start            = valid_in & ~flush & (mem_read | mem_write);
  assign addr_d           = alu_result[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^alu_result[DATA_WIDTH-1:ADDR_WIDTH+2];

  // Access size, aligned lane offset, byte enables and replicated store data
  always_comb begin
    size_d  = SZ_W;
    off_d   = 2'b00;
    be_d    = 4'hF;
    wdata_d = read_data_2;
    if (func_3_bits[1:0] == 2'b00) begin
      size_d = SZ_B;
    end else if (func_3_bits[1:0] == 2'b01) begin
      size_d = SZ_H;
    end
    case (size_d)
      SZ_B:    off_d = alu_result[1:0];
      SZ_H:    off_d = {alu_result[1], 1'b0};
      default: off_d = 2'b00;
    endcase
    if (mem_write) begin
      case (size_d)
        SZ_B: begin
          be_d    = 4'b0001 << off_d;
          wdata_d = {4{read_data_2[7:0]}};
        end
        SZ_H: begin
          be_d    = 4'b0011 << off_d;
          wdata_d = {2{read_data_2[15:0]}};
        end
        default: begin
          be_d    = 4'hF;
          wdata_d = read_data_2;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_d;
  logic trap_q;

  // Half with odd offset or word with any nonzero offset
  always_comb begin
    misalign_d = 1'b0;
    if (size_d == SZ_H) begin
      misalign_d = alu_result[0];
    end else if (size_d == SZ_W) begin
      misalign_d = (alu_result[1:0] != 2'b00);
    end
  end

  assign misalign_trap = trap_q;
`else
  assign misalign_trap = 1'b0;
`endif

  // Load lane selection and extension from the returned word
  always_comb begin
    load_d   = dmem_rdata;
    byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      SZ_B:    load_d = sext_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      SZ_H:    load_d = sext_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      default: load_d = dmem_rdata;
    endcase
  end

  // Access FSM with registered memory-side outputs and result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'h0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      load_q  <= '0;
      kill_q  <= 1'b0;
      off_q   <= 2'b00;
      size_q  <= SZ_W;
      sext_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          kill_q <= 1'b0;
          if (start) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (misalign_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              trap_q  <= 1'b1;
            end else begin
`endif
              state_q <= S_REQ;
              req_q   <= 1'b1;
              we_q    <= mem_write;
              addr_q  <= addr_d;
              be_q    <= be_d;
              wdata_q <= wdata_d;
              off_q   <= off_d;
              size_q  <= size_d;
              sext_q  <= ~func_3_bits[2];
`ifdef LSU_MISALIGN_TRAP_EN
            end
`endif
          end
        end
        S_REQ: begin
          // A kill during REQ lets the access finish but hides its result
          kill_q <= kill_q | flush;
          if (dmem_ack) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            if (!(kill_q | flush)) begin
              done_q <= 1'b1;
              if (!we_q) begin
                load_q <= load_d;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall is combinational so the front end freezes in the start cycle
  assign stall = ~RST & (((state_q == S_IDLE) & start) | (state_q == S_REQ));

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign done       = done_q;
  assign load_data  = load_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with an expectation scoreboard.
module tb_mem_stage_lsu;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        valid_in = 1'b0, flush = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  func_3_bits = 3'b000;
  logic [31:0] alu_result = '0, read_data_2 = '0, dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        dmem_req, dmem_we, stall, done, misalign_trap;
  logic [9:0]  dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, load_data;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [46:0] req;
    logic [46:0] mask;
    logic        done;
    logic        trap;
    logic [31:0] ld;
    int          reqc;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  mem_stage_lsu dut (
    .CLK(CLK), .RST(RST), .valid_in(valid_in), .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write), .func_3_bits(func_3_bits),
    .alu_result(alu_result), .read_data_2(read_data_2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .done(done),
    .load_data(load_data), .misalign_trap(misalign_trap)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Drive one access, acknowledge it in REQ cycle ack_k (flush in REQ cycle flush_k)
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [31:0] rdata,
                            input int ack_k, input int flush_k,
                            input logic [46:0] exp_req, input logic exp_done,
                            input logic exp_trap, input logic [31:0] exp_ld,
                            input int exp_reqc, input int exp_stalls);
    exp_t e;
    int   k;
    int   ns;
    e.req    = exp_req;
    e.mask   = {1'b1, 10'h3FF, 4'hF, (wr ? 32'hFFFF_FFFF : 32'h0)};
    e.done   = exp_done;
    e.trap   = exp_trap;
    e.ld     = exp_ld;
    e.reqc   = exp_reqc;
    e.stalls = exp_stalls;
    sb.push_back(e);
    valid_in    = 1'b1;
    mem_read    = rd;
    mem_write   = wr;
    func_3_bits = f3;
    alu_result  = addr;
    read_data_2 = rs2;
    dmem_rdata  = 32'h5A5A_5A5A;
    #1;
    ns = (stall === 1'b1) ? 1 : 0;
    tick();
    k = 0;
    while (dmem_req === 1'b1 && k < 20) begin
      k++;
      if (stall === 1'b1) ns++;
      check({tag, "/req"}, 64'({dmem_we, dmem_addr, dmem_be, dmem_wdata} & sb[0].mask),
            64'(sb[0].req & sb[0].mask));
      if (k == flush_k) flush = 1'b1;
      if (k == ack_k) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
      tick();
      dmem_ack   = 1'b0;
      flush      = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
      #1;
    end
    e = sb.pop_front();
    check({tag, "/req_cycles"}, 64'(k), 64'(e.reqc));
    check({tag, "/stall_cycles"}, 64'(ns), 64'(e.stalls));
    check({tag, "/done"}, 64'(done), 64'(e.done));
    check({tag, "/trap"}, 64'(misalign_trap), 64'(e.trap));
    check({tag, "/stall_in_done"}, 64'(stall), 64'(0));
    check({tag, "/load_data"}, 64'(load_data), 64'(e.ld));
    valid_in  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    tick();
    check({tag, "/done_pulse"}, 64'({done, misalign_trap}), 64'(0));
  endtask

  initial begin
    // Reset with a live load presented: stall must stay low
    valid_in = 1'b1;
    mem_read = 1'b1;
    tick();
    tick();
    check("rst/stall", 64'(stall), 64'(0));
    check("rst/req_we", 64'({dmem_req, dmem_we}), 64'(0));
    check("rst/addr_be", 64'({dmem_addr, dmem_be}), 64'(0));
    check("rst/wdata", 64'(dmem_wdata), 64'(0));
    check("rst/done_trap", 64'({done, misalign_trap}), 64'(0));
    check("rst/load_data", 64'(load_data), 64'(0));
    valid_in = 1'b0;
    mem_read = 1'b0;
    RST      = 1'b0;
    tick();

    run_access("SW", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1, 0,
               {1'b1, 10'd4, 4'hF, 32'hDEAD_BEEF}, 1'b1, 1'b0, 32'h0, 1, 2);
    run_access("LB", 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF_7F01, 1, 0,
               {1'b0, 10'd4, 4'hF, 32'h0}, 1'b1, 1'b0, 32'hFFFF_FF80, 1, 2);
    run_access("LBU", 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF_7F01, 1, 0,
               {1'b0, 10'd4, 4'hF, 32'h0}, 1'b1, 1'b0, 32'h0000_0080, 1, 2);
    run_access("LH", 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'h8001_1234, 3, 0,
               {1'b0, 10'd4, 4'hF, 32'h0}, 1'b1, 1'b0, 32'hFFFF_8001, 3, 4);
    run_access("LHU", 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h8001_1234, 1, 0,
               {1'b0, 10'd4, 4'hF, 32'h0}, 1'b1, 1'b0, 32'h0000_8001, 1, 2);
    run_access("SH", 1'b0, 1'b1, 3'b001, 32'h16, 32'h0000_ABCD, 32'h0, 1, 0,
               {1'b1, 10'd5, 4'b1100, 32'hABCD_ABCD}, 1'b1, 1'b0, 32'h0000_8001, 1, 2);
    run_access("SB", 1'b0, 1'b1, 3'b000, 32'h03, 32'h1234_5677, 32'h0, 2, 0,
               {1'b1, 10'd0, 4'b1000, 32'h7777_7777}, 1'b1, 1'b0, 32'h0000_8001, 2, 3);
    run_access("LW_flush", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h1111_1111, 2, 1,
               {1'b0, 10'd8, 4'hF, 32'h0}, 1'b0, 1'b0, 32'h0000_8001, 2, 3);
    run_access("LW", 1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 32'hCAFE_F00D, 1, 0,
               {1'b0, 10'd9, 4'hF, 32'h0}, 1'b1, 1'b0, 32'hCAFE_F00D, 1, 2);
    run_access("L011", 1'b1, 1'b0, 3'b011, 32'h28, 32'h0, 32'h8765_4321, 1, 0,
               {1'b0, 10'd10, 4'hF, 32'h0}, 1'b1, 1'b0, 32'h8765_4321, 1, 2);
    run_access("RW_both", 1'b1, 1'b1, 3'b010, 32'h30, 32'h0BAD_F00D, 32'h0, 1, 0,
               {1'b1, 10'd12, 4'hF, 32'h0BAD_F00D}, 1'b1, 1'b0, 32'h8765_4321, 1, 2);
`ifdef LSU_MISALIGN_TRAP_EN
    run_access("LW_mis", 1'b1, 1'b0, 3'b010, 32'h11, 32'h0, 32'h1357_2468, 1, 0,
               {1'b0, 10'd4, 4'hF, 32'h0}, 1'b1, 1'b1, 32'h8765_4321, 0, 1);
    run_access("SH_mis", 1'b0, 1'b1, 3'b001, 32'h17, 32'h0000_ABCD, 32'h0, 1, 0,
               {1'b1, 10'd5, 4'b1100, 32'hABCD_ABCD}, 1'b1, 1'b1, 32'h8765_4321, 0, 1);
`else
    run_access("LW_mis", 1'b1, 1'b0, 3'b010, 32'h11, 32'h0, 32'h1357_2468, 1, 0,
               {1'b0, 10'd4, 4'hF, 32'h0}, 1'b1, 1'b0, 32'h1357_2468, 1, 2);
    run_access("SH_mis", 1'b0, 1'b1, 3'b001, 32'h17, 32'h0000_ABCD, 32'h0, 1, 0,
               {1'b1, 10'd5, 4'b1100, 32'hABCD_ABCD}, 1'b1, 1'b0, 32'h1357_2468, 1, 2);
`endif

    // Flush in IDLE suppresses the start
    valid_in    = 1'b1;
    mem_read    = 1'b1;
    flush       = 1'b1;
    func_3_bits = 3'b010;
    alu_result  = 32'h40;
    #1;
    check("idle_flush/stall", 64'(stall), 64'(0));
    tick();
    check("idle_flush/req", 64'(dmem_req), 64'(0));
    valid_in = 1'b0;
    mem_read = 1'b0;
    flush    = 1'b0;
    tick();

    // Reset during REQ withdraws the request at once
    valid_in   = 1'b1;
    mem_read   = 1'b1;
    alu_result = 32'h44;
    tick();
    check("rst_req/req_before", 64'(dmem_req), 64'(1));
    RST = 1'b1;
    #1;
    check("rst_req/req", 64'(dmem_req), 64'(0));
    check("rst_req/stall", 64'(stall), 64'(0));
    valid_in = 1'b0;
    mem_read = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    check("rst_req/load_data", 64'(load_data), 64'(0));

    run_access("LW_after_rst", 1'b1, 1'b0, 3'b010, 32'h48, 32'h0, 32'h2468_1357, 1, 0,
               {1'b0, 10'd18, 4'hF, 32'h0}, 1'b1, 1'b0, 32'h2468_1357, 1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
